mm_seq_ctrl: RTL

//  Parametrised loop sequencer for the vector x matrix engine. For N nodes x Co out-words x Ci in-words it issues

---
 rtl/mm_pkg.sv | 26 ++
 rtl/mm_tag_pipe.sv | 34 +++
 rtl/mm_seq_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the vector x matrix loop sequencer: FSM encoding
// and the layout of the per-beat tag that travels to the datapath tap.
package mm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } state_t;

  // Tag bit positions; the write address occupies the top OUT_AW bits.
  localparam int TAG_VALID = 0;
  localparam int TAG_FIRST = 1;
  localparam int TAG_LAST  = 2;
  localparam int TAG_BIAS  = 3;
  localparam int TAG_ACC   = 4;
  localparam int TAG_RELU  = 5;
  localparam int TAG_ADDR  = 6;

  function automatic int tag_width(input int out_aw);
    return TAG_ADDR + out_aw;
  endfunction

endpackage

// File: rtl/mm_tag_pipe.sv
// Fixed-depth shift register carrying beat tags from address issue to the
// datapath result tap; advances every cycle, cleared by reset or flush.
module mm_tag_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst || clr) q_reg <= '0;
          else            q_reg <= din;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (rst || clr) q_reg <= '0;
          else            q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/mm_seq_ctrl.sv
// Loop sequencer for the vector x matrix engine: walks n/co/ci, issues buffer
// addresses and delays per-beat tags to the datapath result tap.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int IN_AW    = 11,
  parameter int W_AW     = 13,
  parameter int OUT_AW   = 11,
  parameter int B_AW     = 9,
  parameter int CI_W     = 8,
  parameter int N_W      = 16,
  parameter int PIPE_LAT = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              abort,
  input  logic [CI_W-1:0]   cfg_ci,
  input  logic [CI_W-1:0]   cfg_co,
  input  logic [N_W-1:0]    cfg_n,
  input  logic              cfg_relu,
  input  logic              cfg_bias,
  input  logic              cfg_acc,
  input  logic [W_AW-1:0]   cfg_w_base,
  input  logic [IN_AW-1:0]  cfg_in_base,
  input  logic [OUT_AW-1:0] cfg_out_base,
  input  logic [B_AW-1:0]   cfg_b_base,
  input  logic              issue_stall,
  output logic [W_AW-1:0]   weight_addr,
  output logic              weight_addr_valid,
  output logic [IN_AW-1:0]  input_addr,
  output logic              input_addr_valid,
  output logic [B_AW-1:0]   bias_addr,
  output logic              bias_addr_valid,
  output logic [OUT_AW-1:0] acc_rd_addr,
  output logic              acc_rd_addr_valid,
  output logic              dp_valid,
  output logic              dp_first,
  output logic              dp_last,
  output logic              dp_add_bias,
  output logic              dp_add_acc,
  output logic              dp_relu,
  output logic [OUT_AW-1:0] wr_addr,
  output logic              wr_valid,
  output logic              done,
  output logic              cfg_err
);

  localparam int TW = tag_width(OUT_AW);
  localparam int FW = $clog2(PIPE_LAT + 1) + 1;

  state_t state_reg, state_next;
  logic [CI_W-1:0]   ci_dim_reg, co_dim_reg, ci_reg, co_reg;
  logic [N_W-1:0]    n_dim_reg, n_reg;
  logic              relu_reg, bias_reg, acc_reg;
  logic [W_AW-1:0]   w_base_reg, w_addr_reg;
  logic [IN_AW-1:0]  in_node_reg;
  logic [OUT_AW-1:0] acc_node_reg, acc_addr;
  logic [B_AW-1:0]   b_base_reg;
  logic [FW-1:0]     inflight_reg, inflight_next;
  logic              dims_ok, accept, issue, last_ci, last_co, last_n, tap_valid;
  logic [TW-1:0]     tag_in, tag_out;

  assign dims_ok  = (cfg_ci != '0) && (cfg_co != '0) && (cfg_n != '0);
  assign accept   = (state_reg == ST_IDLE) && start_valid && !abort;
  assign issue    = (state_reg == ST_ISSUE) && !issue_stall && !abort;
  assign last_ci  = ci_reg == ci_dim_reg - CI_W'(1);
  assign last_co  = co_reg == co_dim_reg - CI_W'(1);
  assign last_n   = n_reg == n_dim_reg - N_W'(1);
  assign acc_addr = acc_node_reg + OUT_AW'(co_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_valid) state_next = dims_ok ? ST_ISSUE : ST_ERR;
      ST_ISSUE: if (issue && last_ci && last_co && last_n) state_next = ST_DRAIN;
      ST_DRAIN: if (inflight_next == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Looking at the next count lets DONE follow the final tap by one cycle.
  always_comb begin
    inflight_next = inflight_reg;
    if (issue && !tap_valid)      inflight_next = inflight_reg + FW'(1);
    else if (!issue && tap_valid) inflight_next = inflight_reg - FW'(1);
    if (abort) inflight_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      inflight_reg <= '0;
      ci_dim_reg   <= '0;
      co_dim_reg   <= '0;
      n_dim_reg    <= '0;
      ci_reg       <= '0;
      co_reg       <= '0;
      n_reg        <= '0;
      relu_reg     <= 1'b0;
      bias_reg     <= 1'b0;
      acc_reg      <= 1'b0;
      w_base_reg   <= '0;
      w_addr_reg   <= '0;
      in_node_reg  <= '0;
      acc_node_reg <= '0;
      b_base_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= inflight_next;
      if (abort) begin
        ci_reg <= '0;
        co_reg <= '0;
        n_reg  <= '0;
      end else if (accept && dims_ok) begin
        ci_dim_reg   <= cfg_ci;
        co_dim_reg   <= cfg_co;
        n_dim_reg    <= cfg_n;
        relu_reg     <= cfg_relu;
        bias_reg     <= cfg_bias;
        acc_reg      <= cfg_acc;
        w_base_reg   <= cfg_w_base;
        w_addr_reg   <= cfg_w_base;
        in_node_reg  <= cfg_in_base;
        acc_node_reg <= cfg_out_base;
        b_base_reg   <= cfg_b_base;
        ci_reg       <= '0;
        co_reg       <= '0;
        n_reg        <= '0;
      end else if (issue) begin
        if (!last_ci) begin
          ci_reg     <= ci_reg + CI_W'(1);
          w_addr_reg <= w_addr_reg + W_AW'(1);
        end else begin
          ci_reg <= '0;
          if (!last_co) begin
            co_reg     <= co_reg + CI_W'(1);
            w_addr_reg <= w_addr_reg + W_AW'(1);
          end else begin
            // End of a node: the same weights are replayed for the next one.
            co_reg       <= '0;
            w_addr_reg   <= w_base_reg;
            n_reg        <= last_n ? '0 : n_reg + N_W'(1);
            in_node_reg  <= in_node_reg + IN_AW'(ci_dim_reg);
            acc_node_reg <= acc_node_reg + OUT_AW'(co_dim_reg);
          end
        end
      end
    end
  end

  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in[TAG_VALID]             = 1'b1;
      tag_in[TAG_FIRST]             = ci_reg == '0;
      tag_in[TAG_LAST]              = last_ci;
      tag_in[TAG_BIAS]              = last_ci && bias_reg;
      tag_in[TAG_ACC]               = last_ci && acc_reg;
      tag_in[TAG_RELU]              = last_ci && relu_reg;
      tag_in[TAG_ADDR +: OUT_AW]    = acc_addr;
    end
  end

  mm_tag_pipe #(.WIDTH(TW), .DEPTH(PIPE_LAT)) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign tap_valid         = tag_out[TAG_VALID];
  assign start_ready       = state_reg == ST_IDLE;
  assign input_addr_valid  = issue;
  assign weight_addr_valid = issue;
  assign input_addr        = issue ? in_node_reg + IN_AW'(ci_reg) : '0;
  assign weight_addr       = issue ? w_addr_reg : '0;
  assign bias_addr_valid   = issue && last_ci && bias_reg;
  assign bias_addr         = bias_addr_valid ? b_base_reg + B_AW'(co_reg) : '0;
  assign acc_rd_addr_valid = issue && last_ci && acc_reg;
  assign acc_rd_addr       = acc_rd_addr_valid ? acc_addr : '0;
  assign dp_valid          = tap_valid;
  assign dp_first          = tag_out[TAG_FIRST];
  assign dp_last           = tag_out[TAG_LAST];
  assign dp_add_bias       = tag_out[TAG_BIAS];
  assign dp_add_acc        = tag_out[TAG_ACC];
  assign dp_relu           = tag_out[TAG_RELU];
  assign wr_valid          = tap_valid && tag_out[TAG_LAST];
  assign wr_addr           = wr_valid ? tag_out[TAG_ADDR +: OUT_AW] : '0;
  assign done              = (state_reg == ST_DONE) || (state_reg == ST_ERR);
  assign cfg_err           = state_reg == ST_ERR;

endmodule
